complete_stage: RTL and testbench
=================================

Name: complete_stage

Overview:
Completion stage directly downstream of the functional-unit block.
- Accepts at most one completed instruction per cycle: dest physical reg, value, ROB index and branch outcome.
- Buffers completions in a small in-order FIFO.
- Retires one entry per cycle onto the CDB (PRF write + RS wakeup tag) and the ROB complete port.
- Applies backpressure to the FU block when the FIFO nears full, and is cleared on branch-mispredict flush.

Parameters:
XLEN, 32, data/PC width
PR_IDX_W, 6, physical register index width
ROB_IDX_W, 5, ROB index width
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
flush  input  1  synchronous squash (mispredict); empties the FIFO
in_valid  input  1  FU presents a completion this cycle
in_pr_idx  input  PR_IDX_W  destination physical register (0 = no destination)
in_rob_idx  input  ROB_IDX_W  ROB entry of the instruction
in_value  input  XLEN  result value
in_take_branch  input  1  branch resolved taken
in_target_pc  input  XLEN  resolved branch target
cdb_stall  input  1  CDB unavailable this cycle; hold head
in_ready  output  1  FIFO can accept a completion this cycle
stall_fu  output  1  almost-full backpressure to FU/dispatch
cdb_valid  output  1  broadcast head result to PRF/RS
cdb_pr_idx  output  PR_IDX_W  broadcast tag
cdb_value  output  XLEN  broadcast value
rob_valid  output  1  mark head ROB entry complete
rob_idx  output  ROB_IDX_W  ROB entry being completed
rob_take_branch  output  1  head branch outcome
rob_target_pc  output  XLEN  head branch target
occupancy  output  $clog2(DEPTH)+1  current entry count

Behaviour:
- Storage: DEPTH-entry circular FIFO.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (async): head = tail = count = 0; all outputs 0, except in_ready = 1.
- Ready/backpressure:
  - in_ready = (count < DEPTH), from registered count only; a same-cycle pop does not raise it.
  - stall_fu = (count >= DEPTH-1).
- Push occurs when in_valid && in_ready && !flush.
  - The entry is written at tail and tail increments.
  - in_valid while !in_ready: the input is ignored. The FU must hold it; the stage never overwrites an entry.
- Output:
  - out_valid = (count != 0).
  - Head fields are driven combinationally from stored registers, so latency is 1 cycle: a push at edge N is visible on outputs after edge N.
  - rob_valid = out_valid.
  - cdb_valid = out_valid && (head pr_idx != 0); an x0 destination completes in the ROB without a CDB broadcast.
  - cdb_pr_idx, cdb_value and the rob_* fields are forced to 0 when out_valid = 0.
- Pop occurs when out_valid && !cdb_stall && !flush: head increments.
  - Under cdb_stall, all outputs hold the same head entry and rob_valid stays 1. The ROB treats repeated rob_valid for the same rob_idx as idempotent.
- Simultaneous push + pop: count unchanged, both pointers advance. At count = DEPTH no push can occur (in_ready = 0).
- flush (synchronous, highest priority):
  - At the edge, head = tail = count = 0.
  - The same-cycle in_valid is discarded.
  - Outputs are still driven from the current head during the flush cycle.
- Ordering: strictly FIFO; results leave in acceptance order.
- Reset asserted mid-operation clears immediately, independent of clock.

Test Plan:
1. Reset, then a single push (pr=5, rob=3, value=0xDEAD_BEEF) at edge 1, no stall -> after edge 1: cdb_valid=1, cdb_pr_idx=5, rob_idx=3, occupancy=1; after edge 2: cdb_valid=0, rob_valid=0, occupancy=0.
2. cdb_stall=1 held while pushing 4 entries (pr 1..4) -> occupancy reaches 4; stall_fu=1 at occupancy 3; in_ready=0 at 4; a 5th in_valid is ignored. Release stall -> pr 1,2,3,4 emerge on consecutive cycles with pointers wrapping cleanly.
3. Continuous push + pop every cycle for 10 cycles (rob 0..9) -> occupancy stays 1; rob_idx sequence 0..9 in order with no bubbles after the first.
4. Push with in_pr_idx=0, rob=7 -> rob_valid=1, rob_idx=7, cdb_valid=0.
5. Branch push (take=1, target=0x0000_0400) -> rob_take_branch=1, rob_target_pc=0x400 for exactly the cycle of that head.
6. Occupancy=3, then flush=1 with in_valid=1 on the same cycle -> after the edge occupancy=0, all valids 0, the new input is dropped. Async reset pulse mid-stream -> outputs clear before the next clock edge.

Source files
------------

// File: rtl/complete_stage.sv
// Completion stage: buffers FU completions in an in-order FIFO and
// retires one per cycle onto the CDB and the ROB complete port.
//
// Ports:
//   clock, reset (async, active-high), flush (sync squash)
//   in_*      : completion from the FU block (in_valid/in_ready)
//   cdb_stall : CDB unavailable, hold head
//   stall_fu  : almost-full backpressure
//   cdb_*     : PRF write / RS wakeup broadcast of head
//   rob_*     : ROB complete port for head
//   occupancy : current entry count
module complete_stage #(
  parameter int XLEN      = 32,
  parameter int PR_IDX_W  = 6,
  parameter int ROB_IDX_W = 5,
  parameter int DEPTH     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [PR_IDX_W-1:0]    in_pr_idx,
  input  logic [ROB_IDX_W-1:0]   in_rob_idx,
  input  logic [XLEN-1:0]        in_value,
  input  logic                   in_take_branch,
  input  logic [XLEN-1:0]        in_target_pc,
  input  logic                   cdb_stall,
  output logic                   in_ready,
  output logic                   stall_fu,
  output logic                   cdb_valid,
  output logic [PR_IDX_W-1:0]    cdb_pr_idx,
  output logic [XLEN-1:0]        cdb_value,
  output logic                   rob_valid,
  output logic [ROB_IDX_W-1:0]   rob_idx,
  output logic                   rob_take_branch,
  output logic [XLEN-1:0]        rob_target_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(DEPTH - 1);

  logic [PR_IDX_W-1:0]  pr_mem  [DEPTH];
  logic [ROB_IDX_W-1:0] rob_mem [DEPTH];
  logic [XLEN-1:0]      val_mem [DEPTH];
  logic                 tk_mem  [DEPTH];
  logic [XLEN-1:0]      tgt_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic out_valid;
  logic push;
  logic pop;

  // Ready comes from the registered count only, so a pop in the
  // same cycle never lets a push into a full FIFO.
  assign in_ready  = count < FULL;
  assign stall_fu  = count >= AFULL;
  assign out_valid = count != '0;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && !cdb_stall && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read when count != 0.
  always_ff @(posedge clock) begin
    if (push) begin
      pr_mem[tail]  <= in_pr_idx;
      rob_mem[tail] <= in_rob_idx;
      val_mem[tail] <= in_value;
      tk_mem[tail]  <= in_take_branch;
      tgt_mem[tail] <= in_target_pc;
    end
  end

  // x0 destinations complete in the ROB without a CDB broadcast.
  assign rob_valid = out_valid;
  assign cdb_valid = out_valid && (pr_mem[head] != '0);

  assign cdb_pr_idx      = out_valid ? pr_mem[head]  : '0;
  assign cdb_value       = out_valid ? val_mem[head] : '0;
  assign rob_idx         = out_valid ? rob_mem[head] : '0;
  assign rob_take_branch = out_valid ? tk_mem[head]  : 1'b0;
  assign rob_target_pc   = out_valid ? tgt_mem[head] : '0;

  assign occupancy = count;

endmodule

// File: tb/tb_complete_stage.sv
// Self-checking bench for complete_stage: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_complete_stage;

  localparam int XLEN  = 32;
  localparam int PRW   = 6;
  localparam int ROBW  = 5;
  localparam int DEPTH = 4;

  logic            clock;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic [PRW-1:0]  in_pr_idx;
  logic [ROBW-1:0] in_rob_idx;
  logic [XLEN-1:0] in_value;
  logic            in_take_branch;
  logic [XLEN-1:0] in_target_pc;
  logic            cdb_stall;
  logic            in_ready;
  logic            stall_fu;
  logic            cdb_valid;
  logic [PRW-1:0]  cdb_pr_idx;
  logic [XLEN-1:0] cdb_value;
  logic            rob_valid;
  logic [ROBW-1:0] rob_idx;
  logic            rob_take_branch;
  logic [XLEN-1:0] rob_target_pc;
  logic [2:0]      occupancy;

  complete_stage #(
    .XLEN(XLEN), .PR_IDX_W(PRW), .ROB_IDX_W(ROBW), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pr_idx(in_pr_idx),
    .in_rob_idx(in_rob_idx), .in_value(in_value),
    .in_take_branch(in_take_branch), .in_target_pc(in_target_pc),
    .cdb_stall(cdb_stall), .in_ready(in_ready), .stall_fu(stall_fu),
    .cdb_valid(cdb_valid), .cdb_pr_idx(cdb_pr_idx),
    .cdb_value(cdb_value), .rob_valid(rob_valid), .rob_idx(rob_idx),
    .rob_take_branch(rob_take_branch), .rob_target_pc(rob_target_pc),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [PRW-1:0]  pr;
    logic [ROBW-1:0] rob;
    logic [XLEN-1:0] val;
    logic            tk;
    logic [XLEN-1:0] tgt;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference: a queue of accepted completions, updated once per edge.
  task automatic tick();
    ent_t e;
    bit   acc;
    bit   ret;
    @(posedge clock);
    acc = in_valid && (q.size() < DEPTH) && !flush;
    ret = (q.size() != 0) && !cdb_stall && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) begin
        e.pr  = in_pr_idx;
        e.rob = in_rob_idx;
        e.val = in_value;
        e.tk  = in_take_branch;
        e.tgt = in_target_pc;
        q.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic drive(input bit v, input int pr, input int rob,
                       input logic [31:0] val, input bit tk,
                       input logic [31:0] tgt);
    in_valid       = v;
    in_pr_idx      = PRW'(pr);
    in_rob_idx     = ROBW'(rob);
    in_value       = val;
    in_take_branch = tk;
    in_target_pc   = tgt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cdb_stall = 1'b0; idle();
    repeat (2) @(negedge clock);
    checks++;
    if ({in_ready, stall_fu, cdb_valid, rob_valid, occupancy} !== 7'b1000000
        || cdb_pr_idx !== '0 || cdb_value !== '0 || rob_idx !== '0
        || rob_take_branch !== 1'b0 || rob_target_pc !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b sfu=%b cv=%b rv=%b occ=%0d, need rdy=1 rest 0",
               in_ready, stall_fu, cdb_valid, rob_valid, occupancy);
    end
    reset = 1'b0;
    q.delete();
    @(negedge clock);
  endtask

  task automatic test_single();
    drive(1, 5, 3, 32'hDEAD_BEEF, 0, 32'h0);
    tick();
    idle();
    checks++;
    if (cdb_valid !== 1 || cdb_pr_idx !== 5 || rob_idx !== 3
        || occupancy !== 1 || cdb_value !== 32'hDEAD_BEEF
        || rob_valid !== 1) begin
      errors++;
      $display("FAIL single_push: cv=%b pr=%0d rob=%0d occ=%0d val=%h, need 1 5 3 1 deadbeef",
               cdb_valid, cdb_pr_idx, rob_idx, occupancy, cdb_value);
    end
    tick();
    checks++;
    if (cdb_valid !== 0 || rob_valid !== 0 || occupancy !== 0) begin
      errors++;
      $display("FAIL single_drain: cv=%b rv=%b occ=%0d, need 0 0 0",
               cdb_valid, rob_valid, occupancy);
    end
  endtask

  task automatic test_stall_fill();
    cdb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 10 + i, 32'h100 + i, 0, 32'h0);
      tick();
      checks++;
      if (occupancy !== 3'(i) || stall_fu !== (i >= 3)
          || in_ready !== (i < 4)) begin
        errors++;
        $display("FAIL fill_%0d: occ=%0d sfu=%b rdy=%b, need %0d %b %b",
                 i, occupancy, stall_fu, in_ready, i, i >= 3, i < 4);
      end
    end
    drive(1, 9, 20, 32'h999, 0, 32'h0);
    tick();
    checks++;
    if (occupancy !== 4 || cdb_pr_idx !== 1) begin
      errors++;
      $display("FAIL full_ignore: occ=%0d pr=%0d, need 4 1",
               occupancy, cdb_pr_idx);
    end
    idle();
    cdb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (cdb_pr_idx !== PRW'(i) || cdb_valid !== 1
          || cdb_value !== 32'h100 + i) begin
        errors++;
        $display("FAIL drain_%0d: pr=%0d cv=%b val=%h, need %0d 1 %h",
                 i, cdb_pr_idx, cdb_valid, cdb_value, i, 32'h100 + i);
      end
      tick();
    end
    checks++;
    if (occupancy !== 0) begin
      errors++;
      $display("FAIL drain_empty: occ=%0d, need 0", occupancy);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      drive(1, k + 1, k, 32'(k * 7), 0, 32'h0);
      tick();
      checks++;
      if (occupancy !== 1 || rob_idx !== ROBW'(k) || rob_valid !== 1) begin
        errors++;
        $display("FAIL stream_%0d: occ=%0d rob=%0d rv=%b, need 1 %0d 1",
                 k, occupancy, rob_idx, rob_valid, k);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_x0();
    drive(1, 0, 7, 32'h1234, 0, 32'h0);
    tick();
    idle();
    checks++;
    if (rob_valid !== 1 || rob_idx !== 7 || cdb_valid !== 0) begin
      errors++;
      $display("FAIL x0_dest: rv=%b rob=%0d cv=%b, need 1 7 0",
               rob_valid, rob_idx, cdb_valid);
    end
    tick();
  endtask

  task automatic test_branch();
    drive(1, 3, 2, 32'h55, 1, 32'h0000_0400);
    tick();
    drive(1, 4, 4, 32'h66, 0, 32'h0);
    checks++;
    if (rob_take_branch !== 1 || rob_target_pc !== 32'h400 || rob_idx !== 2) begin
      errors++;
      $display("FAIL branch_head: tk=%b tgt=%h rob=%0d, need 1 400 2",
               rob_take_branch, rob_target_pc, rob_idx);
    end
    tick();
    idle();
    checks++;
    if (rob_take_branch !== 0 || rob_target_pc !== 0 || rob_idx !== 4) begin
      errors++;
      $display("FAIL branch_next: tk=%b tgt=%h rob=%0d, need 0 0 4",
               rob_take_branch, rob_target_pc, rob_idx);
    end
    tick();
    checks++;
    if (rob_take_branch !== 0 || rob_valid !== 0) begin
      errors++;
      $display("FAIL branch_empty: tk=%b rv=%b, need 0 0",
               rob_take_branch, rob_valid);
    end
  endtask

  task automatic test_flush();
    cdb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 20 + i, 16 + i, 32'hF0 + i, 0, 32'h0);
      tick();
    end
    checks++;
    if (occupancy !== 3) begin
      errors++;
      $display("FAIL pre_flush: occ=%0d, need 3", occupancy);
    end
    cdb_stall = 1'b0;
    flush = 1'b1;
    drive(1, 30, 30, 32'hABC, 0, 32'h0);
    #1;
    checks++;
    if (rob_valid !== 1 || rob_idx !== 16) begin
      errors++;
      $display("FAIL flush_cycle_out: rv=%b rob=%0d, need 1 16",
               rob_valid, rob_idx);
    end
    tick();
    flush = 1'b0;
    idle();
    checks++;
    if (occupancy !== 0 || rob_valid !== 0 || cdb_valid !== 0
        || in_ready !== 1) begin
      errors++;
      $display("FAIL post_flush: occ=%0d rv=%b cv=%b rdy=%b, need 0 0 0 1",
               occupancy, rob_valid, cdb_valid, in_ready);
    end
    tick();
    checks++;
    if (occupancy !== 0 || rob_valid !== 0) begin
      errors++;
      $display("FAIL flush_drop: occ=%0d rv=%b, need 0 0",
               occupancy, rob_valid);
    end
  endtask

  task automatic test_async_reset();
    cdb_stall = 1'b1;
    drive(1, 11, 1, 32'h1, 0, 32'h0);
    tick();
    drive(1, 12, 2, 32'h2, 0, 32'h0);
    tick();
    idle();
    cdb_stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (occupancy !== 0 || rob_valid !== 0 || cdb_valid !== 0
        || in_ready !== 1 || stall_fu !== 0) begin
      errors++;
      $display("FAIL async_reset: occ=%0d rv=%b cv=%b rdy=%b, need 0 0 0 1",
               occupancy, rob_valid, cdb_valid, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    @(negedge clock);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      ent_t h;
      bit   ev;
      ev = q.size() != 0;
      if (ev) h = q[0];
      checks++;
      if (occupancy !== 3'(q.size())
          || in_ready !== (q.size() < DEPTH)
          || stall_fu !== (q.size() >= DEPTH - 1)
          || rob_valid !== ev
          || cdb_valid !== (ev && h.pr != 0)
          || cdb_pr_idx !== (ev ? h.pr : '0)
          || cdb_value !== (ev ? h.val : '0)
          || rob_idx !== (ev ? h.rob : '0)
          || rob_take_branch !== (ev ? h.tk : 1'b0)
          || rob_target_pc !== (ev ? h.tgt : '0)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_%0d: occ=%0d rv=%b cv=%b pr=%0d rob=%0d, need occ=%0d rv=%b pr=%0d rob=%0d",
                   c, occupancy, rob_valid, cdb_valid, cdb_pr_idx, rob_idx,
                   q.size(), ev, ev ? h.pr : 0, ev ? h.rob : 0);
      end
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 63),
            $urandom_range(0, 31), $urandom, $urandom_range(0, 1),
            $urandom);
      cdb_stall = $urandom_range(0, 9) < 3;
      flush     = $urandom_range(0, 19) == 0;
      tick();
    end
    flush = 1'b0;
    cdb_stall = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_fill();
    test_back_to_back();
    test_x0();
    test_branch();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
